bus_generator_arbiter: RTL and testbench



---
 rtl/bus_generator_arbiter.sv | 139 +++++++++++++
 tb/tb_bus_generator_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bus_generator_arbiter.sv
// bus_generator_arbiter: shared-bus emulator and round-robin arbiter.
// Each bus index is an independent arbiter that pops one packet from a
// pending device and routes it by the 8-bit destination ID held in the
// packet's top byte (unicast, or broadcast to every device except the sender).
//
// Build option:
//   BS_BROADCAST_EN - when defined, ID == broadcast is delivered to all other
//                     devices; when undefined it is popped and dropped like
//                     any other unknown ID.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a pending device; issues the pop pulse on grant
// POP   | captures the granted head packet and decodes its destination
// PUSH  | push pulse is on the bus; returns to IDLE next cycle
module bus_generator_arbiter #(
    parameter int          bits      = 1,
    parameter int          drvrs     = 4,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [bits-1:0][drvrs-1:0]                 pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [bits-1:0][drvrs-1:0]                 pop,
    output logic [bits-1:0][drvrs-1:0]                 push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]    D_push
);

    localparam int idx_w = (drvrs > 1) ? $clog2(drvrs) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    genvar b;
    generate
        for (b = 0; b < bits; b++) begin : g_bus
            state_t             state_q, state_d;
            logic [idx_w-1:0]   rr_q, rr_d;
            logic [idx_w-1:0]   grant_q, grant_d;
            logic [idx_w-1:0]   cand;
            logic               found;
            logic [drvrs-1:0]   pop_q, pop_d;
            logic [drvrs-1:0]   push_q, push_d;
            logic [pckg_sz-1:0] pkt_q, pkt_d;
            logic [7:0]         dest;

            // State, round-robin pointer, grant and registered outputs.
            // The pointer resets to the last device so device 0 wins first.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= IDLE;
                    rr_q    <= idx_w'(drvrs - 1);
                    grant_q <= '0;
                    pop_q   <= '0;
                    push_q  <= '0;
                    pkt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    rr_q    <= rr_d;
                    grant_q <= grant_d;
                    pop_q   <= pop_d;
                    push_q  <= push_d;
                    pkt_q   <= pkt_d;
                end
            end

            // Next-state logic: round-robin grant search, capture and routing.
            always_comb begin
                state_d = state_q;
                rr_d    = rr_q;
                grant_d = grant_q;
                pop_d   = '0;
                push_d  = '0;
                pkt_d   = pkt_q;
                cand    = '0;
                found   = 1'b0;
                dest    = D_pop[b][grant_q][pckg_sz-1 -: 8];

                case (state_q)
                    IDLE: begin
                        // Search starts one past the last grant and wraps.
                        for (int i = 1; i <= drvrs; i++) begin
                            cand = idx_w'((int'(rr_q) + i) % drvrs);
                            if (!found && pndng[b][cand]) begin
                                found   = 1'b1;
                                grant_d = cand;
                            end
                        end
                        if (found) begin
                            rr_d           = grant_d;
                            pop_d[grant_d] = 1'b1;
                            state_d        = POP;
                        end
                    end

                    POP: begin
                        // The head is taken even if pndng dropped this cycle.
                        pkt_d = D_pop[b][grant_q];
                        if (int'(dest) < drvrs) begin
                            for (int i = 0; i < drvrs; i++) begin
                                push_d[i] = (dest == 8'(i));
                            end
                        end
`ifdef BS_BROADCAST_EN
                        else if (dest == broadcast) begin
                            for (int i = 0; i < drvrs; i++) begin
                                push_d[i] = (i != int'(grant_q));
                            end
                        end
`endif
                        state_d = PUSH;
                    end

                    PUSH: begin
                        state_d = IDLE;
                    end

                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end

            assign pop[b]  = pop_q;
            assign push[b] = push_q;

            // Every lane carries the same delivered packet.
            for (genvar i = 0; i < drvrs; i++) begin : g_lane
                assign D_push[b][i] = pkt_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Testbench for bus_generator_arbiter (drvrs=4, pckg_sz=16, bits=1).
// Table-driven single-packet transactions followed by hand-written
// sequences for back-to-back round-robin and reset during PUSH.
module tb_bus_generator_arbiter;

    localparam int DRV = 4;
    localparam int PW  = 16;

`ifdef BS_BROADCAST_EN
    localparam logic [3:0] BCAST_PUSH = 4'b1101;
`else
    localparam logic [3:0] BCAST_PUSH = 4'b0000;
`endif

    logic                         clk;
    logic                         reset;
    logic [0:0][DRV-1:0]          pndng;
    logic [0:0][DRV-1:0][PW-1:0]  D_pop;
    logic [0:0][DRV-1:0]          pop;
    logic [0:0][DRV-1:0]          push;
    logic [0:0][DRV-1:0][PW-1:0]  D_push;

    int checks = 0;
    int errors = 0;

    bus_generator_arbiter #(
        .bits(1), .drvrs(DRV), .pckg_sz(PW), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]         pndng;
        logic [3:0][15:0]   d;
        logic [3:0]         exp_pop;
        logic [3:0]         exp_push;
        logic [15:0]        exp_d;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_lanes(input string name, input logic [15:0] exp);
        for (int l = 0; l < DRV; l++) begin
            check($sformatf("%s lane%0d", name, l), D_push[0][l], exp);
        end
    endtask

    task automatic run_vec(input int n);
        @(negedge clk);
        pndng[0] = vecs[n].pndng;
        D_pop[0] = vecs[n].d;
        @(posedge clk); #1;
        check($sformatf("v%0d pop", n), {12'h0, pop[0]}, {12'h0, vecs[n].exp_pop});
        check($sformatf("v%0d push during pop", n), {12'h0, push[0]}, 16'h0);
        @(negedge clk);
        pndng[0] = '0;
        @(posedge clk); #1;
        check($sformatf("v%0d pop after", n), {12'h0, pop[0]}, 16'h0);
        check($sformatf("v%0d push", n), {12'h0, push[0]}, {12'h0, vecs[n].exp_push});
        check_lanes($sformatf("v%0d D_push", n), vecs[n].exp_d);
        @(posedge clk); #1;
        check($sformatf("v%0d push end", n), {12'h0, push[0]}, 16'h0);
        check($sformatf("v%0d pop end", n), {12'h0, pop[0]}, 16'h0);
    endtask

    initial begin
        int         pop_cyc[$];
        logic [3:0] pop_val[$];
        int         bad_onehot;
        int         bad_overlap;
        int         last_pop;

        vecs[0] = '{4'b1111, {16'h3333, 16'h2222, 16'h1111, 16'h02AB}, 4'b0001, 4'b0100, 16'h02AB};
        vecs[1] = '{4'b0010, {16'h0000, 16'h0000, 16'hFF55, 16'h0000}, 4'b0010, BCAST_PUSH, 16'hFF55};
        vecs[2] = '{4'b0100, {16'h0000, 16'h0712, 16'h0000, 16'h0000}, 4'b0100, 4'b0000, 16'h0712};
        vecs[3] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h02AB}, 4'b0001, 4'b0100, 16'h02AB};
        vecs[4] = '{4'b1000, {16'h03CD, 16'h0000, 16'h0000, 16'h0000}, 4'b1000, 4'b1000, 16'h03CD};
        vecs[5] = '{4'b1111, {16'h0388, 16'h0266, 16'h0055, 16'h0177}, 4'b0001, 4'b0010, 16'h0177};
        vecs[6] = '{4'b1010, {16'h0211, 16'h0000, 16'h0099, 16'h0000}, 4'b0010, 4'b0001, 16'h0099};
        vecs[7] = '{4'b1001, {16'h02EE, 16'h0000, 16'h0000, 16'h0122}, 4'b1000, 4'b0100, 16'h02EE};
        vecs[8] = '{4'b0110, {16'h0000, 16'h0300, 16'h0444, 16'h0000}, 4'b0010, 4'b0000, 16'h0444};
        vecs[9] = '{4'b0100, {16'h0000, 16'h0133, 16'h0000, 16'h0000}, 4'b0100, 4'b0010, 16'h0133};

        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        #2;
        check("reset pop", {12'h0, pop[0]}, 16'h0);
        check("reset push", {12'h0, push[0]}, 16'h0);
        check_lanes("reset D_push", 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 10; n++) run_vec(n);

        // Back-to-back round-robin between devices 0 and 3.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pndng[0] = 4'b1001;
        D_pop[0] = {16'h0101, 16'h0000, 16'h0000, 16'h0101};
        bad_onehot  = 0;
        bad_overlap = 0;
        last_pop    = -10;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (pop[0] != 4'b0000) begin
                if (!$onehot(pop[0])) bad_onehot++;
                pop_cyc.push_back(c);
                pop_val.push_back(pop[0]);
                last_pop = c;
            end
            if ((pop[0] != 4'b0000) && (push[0] != 4'b0000)) bad_overlap++;
            if (c == last_pop + 1) check($sformatf("rr push c%0d", c), {12'h0, push[0]}, 16'h0002);
        end
        pndng[0] = '0;
        check("rr pop count", 16'(pop_cyc.size()), 16'd5);
        if (pop_cyc.size() >= 4) begin
            check("rr grant0", {12'h0, pop_val[0]}, 16'h0001);
            check("rr grant1", {12'h0, pop_val[1]}, 16'h0008);
            check("rr grant2", {12'h0, pop_val[2]}, 16'h0001);
            check("rr grant3", {12'h0, pop_val[3]}, 16'h0008);
            check("rr first cycle", 16'(pop_cyc[0]), 16'd0);
            for (int k = 1; k < 4; k++) begin
                check($sformatf("rr spacing %0d", k), 16'(pop_cyc[k] - pop_cyc[k-1]), 16'd3);
            end
        end
        check("rr pop onehot", 16'(bad_onehot), 16'd0);
        check("rr pop/push overlap", 16'(bad_overlap), 16'd0);

        // Reset asserted while push is high.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pndng[0] = 4'b0100;
        D_pop[0] = {16'h0000, 16'h0012, 16'h0000, 16'h0000};
        @(posedge clk); #1;
        check("rst pop", {12'h0, pop[0]}, 16'h0004);
        @(negedge clk);
        pndng[0] = '0;
        @(posedge clk); #1;
        check("rst push before", {12'h0, push[0]}, 16'h0001);
        #1 reset = 1'b1;
        #1;
        check("rst push cleared", {12'h0, push[0]}, 16'h0);
        check("rst pop cleared", {12'h0, pop[0]}, 16'h0);
        check_lanes("rst D_push cleared", 16'h0);
        @(negedge clk);
        reset = 1'b0;
        pndng[0] = 4'b1111;
        D_pop[0] = {16'h0000, 16'h0000, 16'h0000, 16'h0101};
        @(posedge clk); #1;
        check("rst resume grant", {12'h0, pop[0]}, 16'h0001);
        @(negedge clk);
        pndng[0] = '0;
        @(posedge clk); #1;
        check("rst resume push", {12'h0, push[0]}, 16'h0002);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
